// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block builder: padding constant,
// block-count helper and builder state encoding.
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, FILL, PRESENT} builder_state_e;

  // Blocks needed for a message of 'words' words plus marker and 64-bit length.
  function automatic int sha256_num_blocks(input int words);
    return (words + 2) / 16 + 1;
  endfunction

endpackage

// File: rtl/sha256_pad_word_sel.sv
// Chooses the word written into a block slot: message data, pad marker,
// bit length or zero fill, based on the global word index.
module sha256_pad_word_sel
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic [11:0] g,
  input  logic [3:0]  w,
  input  logic        last,
  input  logic [31:0] mem_read_data,
  output logic [31:0] word
);

  localparam logic [11:0] MSG_WORDS = 12'(NUM_OF_WORDS);
  localparam logic [31:0] BIT_LEN   = 32'(NUM_OF_WORDS) << 5;

  always_comb begin
    if (g < MSG_WORDS) begin
      word = mem_read_data;
    end else if (g == MSG_WORDS) begin
      word = SHA256_PAD_WORD;
    end else if (last && (w == 4'd15)) begin
      word = BIT_LEN;
    end else begin
      word = '0;
    end
  end

endmodule

// File: rtl/sha256_block_builder.sv
// Reads a message from synchronous memory, pads it per SHA-256 and hands
// complete 512-bit blocks to the compression stage over valid/ready.
module sha256_block_builder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         busy,
  output logic         done
);

  localparam int          NUM_BLOCKS = sha256_num_blocks(NUM_OF_WORDS);
  localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);
  localparam logic [11:0] MSG_WORDS  = 12'(NUM_OF_WORDS);

  builder_state_e state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  blk_q, blk_d;
  logic [4:0]  w_q, w_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] words_q [16];
  logic [31:0] words_d [16];

  logic [3:0]  slot_w;
  logic [11:0] slot_g, next_g, nb_g;
  logic [7:0]  blk_inc;
  logic        is_last;
  logic [31:0] slot_word;

  // w_q is the slot whose address is on mem_addr; the slot written is one behind it.
  assign slot_w  = 4'(w_q - 5'd1);
  assign slot_g  = {blk_q, slot_w};
  assign next_g  = {blk_q, 4'(w_q + 5'd1)};
  assign blk_inc = blk_q + 8'd1;
  assign nb_g    = {blk_inc, 4'b0000};
  assign is_last = (blk_q == LAST_BLK);

  sha256_pad_word_sel #(.NUM_OF_WORDS(NUM_OF_WORDS)) u_sel (
    .g             (slot_g),
    .w             (slot_w),
    .last          (is_last),
    .mem_read_data (mem_read_data),
    .word          (slot_word)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    blk_d      = blk_q;
    w_d        = w_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    words_d    = words_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = message_addr;
          mem_addr_d = message_addr;
          blk_d      = '0;
          w_d        = '0;
          busy_d     = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (w_q != 5'd0) words_d[slot_w] = slot_word;
        if (w_q == 5'd16) begin
          valid_d = 1'b1;
          last_d  = is_last;
          state_d = PRESENT;
        end else begin
          w_d = w_q + 5'd1;
          // Address only real message words; pad slots leave mem_addr parked.
          if ((w_q < 5'd15) && (next_g < MSG_WORDS)) mem_addr_d = base_q + 16'(next_g);
        end
      end
      PRESENT: begin
        if (blk_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            blk_d   = blk_inc;
            w_d     = '0;
            state_d = FILL;
            if (nb_g < MSG_WORDS) mem_addr_d = base_q + 16'(nb_g);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      blk_q      <= '0;
      w_q        <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) words_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      blk_q      <= blk_d;
      w_q        <= w_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    blk_data = '0;
    for (int unsigned i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = words_q[i];
  end

  assign mem_addr  = mem_addr_q;
  assign blk_valid = valid_q;
  assign blk_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_block_builder.sv
// Directed bench for sha256_block_builder: three instances (20, 13 and 14
// message words) sharing one synchronous memory model.
module tb_sha256_block_builder;

  localparam int WS [3] = '{20, 13, 14};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start    [3];
  logic [15:0]  maddr_in [3];
  logic [15:0]  mem_addr [3];
  logic [31:0]  rdata    [3];
  logic         vld      [3];
  logic         rdy      [3];
  logic [511:0] bdata    [3];
  logic         lst      [3];
  logic         bsy      [3];
  logic         dn       [3];
  logic [31:0]  mem [0:65535];

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    sha256_block_builder #(.NUM_OF_WORDS(WS[k])) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start[k]),
      .message_addr  (maddr_in[k]),
      .mem_addr      (mem_addr[k]),
      .mem_read_data (rdata[k]),
      .blk_valid     (vld[k]),
      .blk_ready     (rdy[k]),
      .blk_data      (bdata[k]),
      .blk_last      (lst[k]),
      .busy          (bsy[k]),
      .done          (dn[k])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) rdata[k] <= mem[mem_addr[k]];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int cyc);
    cyc = 0;
    while (vld[k] !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_to_done(input int k, input string tag);
    int cyc;
    cyc = 0;
    while (dn[k] !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk(tag, 576'(dn[k]), 576'(1'b1));
  endtask

  function automatic logic [511:0] pack(input logic [31:0] a [16]);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = a[i];
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0]  ew [16];
    logic [15:0]  a;
    logic [575:0] snap;
    int           cyc;
    int           changes;

    for (int i = 0; i < 20; i++) begin
      mem[100 + i] = 32'(i + 1);
      a = 16'hFFFE + 16'(i);
      mem[a] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      maddr_in[k] = 16'd100;
      rdy[k] = 1'b1;
    end

    // Reset values
    reset_n = 1'b0;
    tick(); tick();
    chk("reset_outputs", 576'({mem_addr[0], vld[0], bdata[0], lst[0], bsy[0], dn[0]}), '0);
    reset_n = 1'b1;
    tick();

    // 1: W=20, two blocks, latency and throughput
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("t1_busy", 576'(bsy[0]), 576'(1'b1));
    wait_valid(0, cyc);
    chk("t1_latency", 576'(cyc + 1), 576'(18));
    for (int i = 0; i < 16; i++) ew[i] = 32'(i + 1);
    chk("t1_blk0", 576'(bdata[0]), 576'(pack(ew)));
    chk("t1_last0", 576'(lst[0]), '0);
    tick();
    chk("t1_hs_valid_low", 576'(vld[0]), '0);
    wait_valid(0, cyc);
    chk("t1_throughput", 576'(cyc + 1), 576'(18));
    for (int i = 0; i < 16; i++) ew[i] = (i < 4) ? 32'(17 + i) : 32'h0;
    ew[4]  = 32'h8000_0000;
    ew[15] = 32'h0000_0280;
    chk("t1_blk1", 576'(bdata[0]), 576'(pack(ew)));
    chk("t1_last1", 576'(lst[0]), 576'(1'b1));
    tick();
    chk("t1_done", 576'({dn[0], bsy[0], vld[0]}), 576'(3'b100));
    tick();
    chk("t1_done_pulse", 576'(dn[0]), '0);

    // 2: W=13, single block
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_valid(1, cyc);
    chk("t2_valid", 576'(vld[1]), 576'(1'b1));
    for (int i = 0; i < 16; i++) ew[i] = (i < 13) ? 32'(i + 1) : 32'h0;
    ew[13] = 32'h8000_0000;
    ew[15] = 32'h0000_01A0;
    chk("t2_blk0", 576'(bdata[1]), 576'(pack(ew)));
    chk("t2_last", 576'(lst[1]), 576'(1'b1));
    tick();
    chk("t2_done", 576'(dn[1]), 576'(1'b1));

    // 3: W=14, marker fills block 0, block 1 is length only with no reads
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    wait_valid(2, cyc);
    for (int i = 0; i < 16; i++) ew[i] = (i < 14) ? 32'(i + 1) : 32'h0;
    ew[14] = 32'h8000_0000;
    chk("t3_blk0", 576'(bdata[2]), 576'(pack(ew)));
    chk("t3_last0", 576'(lst[2]), '0);
    chk("t3_addr0", 576'(mem_addr[2]), 576'(16'd113));
    tick();
    changes = 0;
    cyc = 0;
    while (vld[2] !== 1'b1 && cyc < 60) begin
      if (mem_addr[2] !== 16'd113) changes++;
      tick();
      cyc++;
    end
    chk("t3_no_reads", 576'(changes), '0);
    for (int i = 0; i < 16; i++) ew[i] = 32'h0;
    ew[15] = 32'h0000_01C0;
    chk("t3_blk1", 576'(bdata[2]), 576'(pack(ew)));
    chk("t3_last1", 576'(lst[2]), 576'(1'b1));
    tick();

    // 4: backpressure in PRESENT
    rdy[0] = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_valid(0, cyc);
    chk("t4_valid", 576'(vld[0]), 576'(1'b1));
    chk("t4_addr", 576'(mem_addr[0]), 576'(16'd115));
    snap = 576'({vld[0], lst[0], mem_addr[0], bdata[0]});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold", 576'({vld[0], lst[0], mem_addr[0], bdata[0]}), snap);
    end
    rdy[0] = 1'b1;
    tick();
    chk("t4_resume", 576'({vld[0], mem_addr[0]}), 576'({1'b0, 16'd116}));
    run_to_done(0, "t4_done");
    tick();

    // 5: reset during FILL word 7
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 576'({mem_addr[0], vld[0], bdata[0], lst[0], bsy[0], dn[0]}), '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_valid(0, cyc);
    for (int i = 0; i < 16; i++) ew[i] = 32'(i + 1);
    chk("t5_blk0", 576'(bdata[0]), 576'(pack(ew)));
    run_to_done(0, "t5_done");
    tick();

    // 6: address wrap and start ignored while busy
    maddr_in[0] = 16'hFFFE;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("t6_addr_fffe", 576'(mem_addr[0]), 576'(16'hFFFE));
    tick();
    chk("t6_addr_ffff", 576'(mem_addr[0]), 576'(16'hFFFF));
    maddr_in[0] = 16'd100;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("t6_addr_0000", 576'(mem_addr[0]), 576'(16'h0000));
    tick();
    chk("t6_addr_0001", 576'(mem_addr[0]), 576'(16'h0001));
    wait_valid(0, cyc);
    for (int i = 0; i < 16; i++) ew[i] = 32'hA000_0000 + 32'(i);
    chk("t6_blk0", 576'(bdata[0]), 576'(pack(ew)));
    run_to_done(0, "t6_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
